// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: handshake FSM states,
// default operand width and the bit-counter width helper.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must index bits 0..width-1; never let it collapse to zero bits.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out of this bit position.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtractor cell and a borrow flop,
// with valid/ready handshakes on operand and result sides.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH:0]   Result,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   result_q, result_d;

  logic             diff_bit;
  logic             borrow_out;

  full_subtractor_cell u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (diff_bit),
    .bout (borrow_out)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (InValid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = 1'b0;
          cnt_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        // Difference bits enter at the top so bit 0 ends up at the LSB after WIDTH shifts.
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = borrow_out;
        cnt_d    = cnt_q + CW'(1);
        result_d = {result_q[WIDTH], diff_bit, result_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          result_d[WIDTH] = borrow_out;
          state_d         = DONE;
        end
      end

      DONE: begin
        if (OutReady) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign InReady  = (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign Result   = result_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, back-pressure and
// reset corner cases, then all operand pairs with random stalls against an arithmetic model.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             InValid;
  logic             InReady;
  logic [WIDTH:0]   Result;
  logic             OutValid;
  logic             OutReady;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   exp;
    int               stall;
    bit               poke;
  } vec_t;

  vec_t vecs[7];
  int   exp_q[$];

  always #5 Clk = ~Clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .A        (A),
    .B        (B),
    .InValid  (InValid),
    .InReady  (InReady),
    .Result   (Result),
    .OutValid (OutValid),
    .OutReady (OutReady)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: two's-complement difference wrapped to WIDTH+1 bits.
  function automatic int model_sub(input int a, input int b);
    return ((a - b) % (1 << (WIDTH + 1)) + (1 << (WIDTH + 1))) % (1 << (WIDTH + 1));
  endfunction

  // Runs one operation starting at a negedge; returns the presented Result.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int stall, input bit poke, output logic [WIDTH:0] res);
    int guard;
    int lat;
    guard = 0;
    while (InReady !== 1'b1 && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    if (InReady !== 1'b1) check("inready_timeout", {31'd0, InReady}, 1);
    A        = a;
    B        = b;
    InValid  = 1'b1;
    OutReady = 1'($urandom_range(0, 1));
    @(negedge Clk);
    InValid = 1'b0;
    A       = WIDTH'($urandom);
    B       = WIDTH'($urandom);
    check("inready_busy", {31'd0, InReady}, 0);
    lat = 0;
    while (OutValid !== 1'b1 && lat < 50) begin
      OutReady = 1'($urandom_range(0, 1));
      @(negedge Clk);
      lat++;
    end
    check("latency", lat, WIDTH);
    OutReady = (stall == 0);
    res      = Result;
    for (int i = 0; i < stall; i++) begin
      if (poke && i == 2) begin
        A       = 4'd1;
        B       = 4'd1;
        InValid = 1'b1;
      end
      @(negedge Clk);
      InValid = 1'b0;
      check("stall_outvalid", {31'd0, OutValid}, 1);
      check("stall_result", {27'd0, Result}, {27'd0, res});
      check("stall_inready", {31'd0, InReady}, 0);
    end
    OutReady = 1'b1;
    @(negedge Clk);
    OutReady = 1'b0;
    check("consumed_outvalid", {31'd0, OutValid}, 0);
    check("consumed_inready", {31'd0, InReady}, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH:0] res;
    int             n_results;

    vecs[0] = '{a: 4'd9,  b: 4'd3,  exp: 5'b00110, stall: 0, poke: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd9,  exp: 5'b11010, stall: 0, poke: 1'b0};
    vecs[2] = '{a: 4'd0,  b: 4'd15, exp: 5'b10001, stall: 0, poke: 1'b0};
    vecs[3] = '{a: 4'd15, b: 4'd0,  exp: 5'b01111, stall: 0, poke: 1'b0};
    vecs[4] = '{a: 4'd7,  b: 4'd7,  exp: 5'b00000, stall: 0, poke: 1'b0};
    vecs[5] = '{a: 4'd12, b: 4'd5,  exp: 5'b00111, stall: 6, poke: 1'b1};
    vecs[6] = '{a: 4'd1,  b: 4'd2,  exp: 5'b11111, stall: 1, poke: 1'b0};

    Rst      = 1'b1;
    A        = '0;
    B        = '0;
    InValid  = 1'b0;
    OutReady = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset_inready", {31'd0, InReady}, 1);
    check("reset_outvalid", {31'd0, OutValid}, 0);
    check("reset_result", {27'd0, Result}, 0);
    Rst = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].poke, res);
      check($sformatf("vec%0d_result", i), {27'd0, res}, {27'd0, vecs[i].exp});
      check($sformatf("vec%0d_sign", i), {31'd0, res[WIDTH]}, {31'd0, vecs[i].a < vecs[i].b});
    end

    // Abort mid-RUN after two bits have been computed.
    A        = 4'd10;
    B        = 4'd4;
    InValid  = 1'b1;
    OutReady = 1'b1;
    @(negedge Clk);
    InValid = 1'b0;
    repeat (2) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("abort_outvalid", {31'd0, OutValid}, 0);
    check("abort_result", {27'd0, Result}, 0);
    check("abort_inready", {31'd0, InReady}, 1);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    do_op(4'd10, 4'd4, 0, 1'b0, res);
    check("after_abort_result", {27'd0, res}, 6);

    n_results = 0;
    for (int a = 0; a < (1 << WIDTH); a++) begin
      for (int b = 0; b < (1 << WIDTH); b++) begin
        exp_q.push_back(model_sub(a, b));
        do_op(WIDTH'(a), WIDTH'(b), $urandom_range(0, 3), 1'b0, res);
        n_results++;
        check($sformatf("sweep_%0d_%0d", a, b), {27'd0, res}, exp_q.pop_front());
      end
    end
    check("sweep_count", n_results, 1 << (2 * WIDTH));
    check("sweep_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor that computes Result = A − B over WIDTH clock cycles, LSB first, using one full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the team's combinational adder. It uses the same operand and result widths (WIDTH in, WIDTH+1 out), so the two can be swapped behind a common handshake in the arithmetic datapath. Valid/ready handshakes on both sides allow back-pressure from the consumer.

## Interface
- WIDTH, default 4: operand width in bits; must be ≥ 2.
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- A  input  WIDTH  minuend, unsigned; sampled on the accept edge.
- B  input  WIDTH  subtrahend, unsigned; sampled on the accept edge.
- InValid  input  1  A/B are valid.
- InReady  output  1  block can accept operands; high only in IDLE.
- Result  output  WIDTH+1  two's-complement A − B; bit WIDTH is the final borrow/sign.
- OutValid  output  1  Result is valid; high only in DONE.
- OutReady  input  1  consumer takes Result.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - InReady = 1.
  - On an edge with InValid & InReady: latch A and B into shift registers, clear borrow, clear bit counter, go to RUN.
- RUN:
  - Each edge computes d = a0 ^ b0 ^ borrow and borrow' = (~a0 & b0) | (~(a0 ^ b0) & borrow) from the current operand LSBs.
  - d shifts into the result register from the MSB side; the operands shift right.
  - The counter increments each edge. On the edge processing bit WIDTH−1: Result[WIDTH] <= borrow', go to DONE.
- DONE:
  - OutValid = 1 and Result is held stable.
  - On an edge with OutReady = 1: go to IDLE.
- Arithmetic:
  - Result equals (A − B) mod 2^(WIDTH+1); range −(2^WIDTH−1) to +(2^WIDTH−1).
  - Result[WIDTH] = 1 exactly when A < B.
- InValid while busy (RUN or DONE) is ignored; the operands are not captured and not queued.
- Operands change after the accept edge: no effect on the operation in progress.
- OutReady high before OutValid: no effect.
- Reset values:
  - State = IDLE, InReady = 1, OutValid = 0, Result = 0, borrow = 0, counter = 0.
  - Reset asserted mid-RUN or in DONE abandons the operation immediately; no partial Result is presented.

## Timing
- Accept at edge T. Bit i is computed at edge T+1+i. OutValid rises after edge T+WIDTH; for WIDTH=4, that is 4 cycles after accept.
- InReady is low from the cycle after the accept edge until the cycle after the consume edge.
- With OutReady tied high, DONE lasts exactly one cycle and InReady returns after edge T+WIDTH+1. The minimum initiation interval is WIDTH+2 cycles.
- Result is registered; no combinational path runs from inputs to outputs.
- OutValid, once high, stays high with Result unchanged until consumed or reset.

## Structure
- Shared package serial_arith_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH constant;
  - the counter-width function (clog2 of WIDTH).
- A sub-module full_subtractor_cell (inputs a, b, bin; outputs d, bout; combinational) is instantiated once inside serial_subtractor.

## Test plan
- Reset, then A=9, B=3 accepted, OutReady=1 → OutValid after 4 cycles, Result=5'b00110 (6); InReady high again the following cycle.
- A=3, B=9 → Result=5'b11010 (−6); A=0, B=15 → Result=5'b10001 (−15); A=15, B=0 → Result=5'b01111; A=7, B=7 → Result=0.
- Back-pressure: A=12, B=5, OutReady=0 for 6 cycles after OutValid rises → Result=7 held stable, InReady=0, and a new InValid pulse with A=1, B=1 is ignored; OutReady=1 → consumed, next operation accepted.
- Rst asserted asynchronously mid-RUN (after 2 bits) with A=10, B=4 → OutValid=0, Result=0, InReady=1 immediately; the next operation A=10, B=4 gives Result=6.
- Exhaustive: all 256 A/B pairs back-to-back with random OutReady stalls → every Result equals (A−B) mod 32, with no lost or duplicated results.
